mem_controller: RTL

Single-port memory controller answering the LoadStoreBuffer's load/store requests and the instruction fetcher's word fetches. It arbitrates between the two, serialises each access into byte transfers on the 8-bit RAM bus, and assembles, sign- or zero-extends and returns load data. It also holds stores to I/O addresses while the UART buffer is full, and aborts speculative reads on a pipeline clear.

---
 rtl/mem_controller.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_controller.sv
// Memory controller: arbitrates LSB loads/stores and instruction fetches onto an
// 8-bit RAM bus, one byte per cycle, and returns extended load data / fetch words.
module mem_controller (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        mem_clear,
  input  logic        lsb_request,
  input  logic        lsb_load_or_store,
  input  logic [5:0]  lsb_op,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_data,
  output logic        lsb_mem_valid,
  output logic [31:0] lsb_mem_val,
  input  logic        if_request,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  localparam logic [5:0]  OP_LB  = 6'd10;
  localparam logic [5:0]  OP_LH  = 6'd11;
  localparam logic [5:0]  OP_LW  = 6'd12;
  localparam logic [5:0]  OP_LBU = 6'd13;
  localparam logic [5:0]  OP_LHU = 6'd14;
  localparam logic [5:0]  OP_SB  = 6'd15;
  localparam logic [5:0]  OP_SH  = 6'd16;
  localparam logic [5:0]  OP_SW  = 6'd17;
  localparam logic [31:0] IO_ADDR0 = 32'h0003_0000;
  localparam logic [31:0] IO_ADDR1 = 32'h0003_0004;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  function automatic logic [2:0] op_len(input logic [5:0] op, input logic is_if);
    if (is_if) begin
      op_len = 3'd4;
    end else begin
      case (op)
        OP_LB, OP_LBU, OP_SB: op_len = 3'd1;
        OP_LH, OP_LHU, OP_SH: op_len = 3'd2;
        default:              op_len = 3'd4;
      endcase
    end
  endfunction

  function automatic logic [31:0] extend(input logic [5:0] op, input logic is_if, input logic [31:0] w);
    if (is_if) begin
      extend = w;
    end else begin
      case (op)
        OP_LB:   extend = {{24{w[7]}}, w[7:0]};
        OP_LH:   extend = {{16{w[15]}}, w[15:0]};
        OP_LBU:  extend = {24'd0, w[7:0]};
        OP_LHU:  extend = {16'd0, w[15:0]};
        OP_LW:   extend = w;
        default: extend = w;
      endcase
    end
  endfunction

  function automatic logic is_io(input logic [31:0] a);
    is_io = (a == IO_ADDR0) || (a == IO_ADDR1);
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  i_q, i_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        is_if_q, is_if_d;
  logic        restart_q, restart_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        lsb_valid_q, lsb_valid_d;
  logic [31:0] lsb_val_q, lsb_val_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_data_q, if_data_d;
  logic [2:0]  len_s;
  logic [1:0]  cap_idx_s;

  assign len_s     = op_len(op_q, is_if_q);
  assign cap_idx_s = i_q[1:0] - 2'd1;

  // Next-state and output computation for the IDLE/READ/WRITE sequencer.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    is_if_d     = is_if_q;
    restart_d   = restart_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = 1'b0;
    lsb_valid_d = 1'b0;
    lsb_val_d   = lsb_val_q;
    if_valid_d  = 1'b0;
    if_data_d   = if_data_q;
    case (state_q)
      S_IDLE: begin
        // The valid-pulse guard keeps a still-high request level from being re-accepted.
        if (rdy_in && !mem_clear && !lsb_valid_q && !if_valid_q && lsb_request) begin
          op_d      = lsb_op;
          addr_d    = lsb_addr;
          is_if_d   = 1'b0;
          restart_d = 1'b0;
          i_d       = 3'd0;
          mem_a_d   = lsb_addr;
          if (lsb_load_or_store) begin
            state_d = S_WRITE;
            data_d  = lsb_data;
            if (is_io(lsb_addr) && io_buffer_full) begin
              mem_wr_d = 1'b0;
            end else begin
              mem_wr_d   = 1'b1;
              mem_dout_d = lsb_data[7:0];
              i_d        = 3'd1;
            end
          end else begin
            state_d = S_READ;
            data_d  = 32'd0;
          end
        end else if (rdy_in && !mem_clear && !lsb_valid_q && !if_valid_q && if_request) begin
          state_d   = S_READ;
          op_d      = 6'd0;
          addr_d    = if_addr;
          is_if_d   = 1'b1;
          restart_d = 1'b0;
          i_d       = 3'd0;
          data_d    = 32'd0;
          mem_a_d   = if_addr;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        // A flush must not be lost while paused, so it is honoured regardless of rdy_in.
        if (mem_clear) begin
          state_d   = S_IDLE;
          restart_d = 1'b0;
        end else if (!rdy_in) begin
          restart_d = 1'b1;
        end else if (restart_q) begin
          restart_d = 1'b0;
          mem_a_d   = addr_q;
          i_d       = 3'd0;
          data_d    = 32'd0;
        end else begin
          if (i_q != 3'd0) begin
            data_d[{cap_idx_s, 3'b000} +: 8] = mem_din;
          end else begin
            data_d = data_q;
          end
          if (i_q == len_s) begin
            state_d = S_IDLE;
            if (is_if_q) begin
              if_valid_d = 1'b1;
              if_data_d  = data_d;
            end else begin
              lsb_valid_d = 1'b1;
              lsb_val_d   = extend(op_q, is_if_q, data_d);
            end
          end else begin
            i_d = i_q + 3'd1;
            if ((i_q + 3'd1) != len_s) begin
              mem_a_d = addr_q + {29'd0, i_q} + 32'd1;
            end else begin
              mem_a_d = mem_a_q;
            end
          end
        end
      end
      S_WRITE: begin
        if (!rdy_in) begin
          mem_wr_d = 1'b0;
        end else if (i_q == len_s) begin
          state_d     = S_IDLE;
          lsb_valid_d = 1'b1;
          lsb_val_d   = 32'd0;
        end else if (is_io(addr_q) && io_buffer_full) begin
          mem_wr_d = 1'b0;
        end else begin
          mem_wr_d   = 1'b1;
          mem_a_d    = addr_q + {29'd0, i_q};
          mem_dout_d = data_q[{i_q[1:0], 3'b000} +: 8];
          i_d        = i_q + 3'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered-output flops.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      i_q         <= 3'd0;
      op_q        <= 6'd0;
      addr_q      <= 32'd0;
      data_q      <= 32'd0;
      is_if_q     <= 1'b0;
      restart_q   <= 1'b0;
      mem_a_q     <= 32'd0;
      mem_dout_q  <= 8'd0;
      mem_wr_q    <= 1'b0;
      lsb_valid_q <= 1'b0;
      lsb_val_q   <= 32'd0;
      if_valid_q  <= 1'b0;
      if_data_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      is_if_q     <= is_if_d;
      restart_q   <= restart_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      lsb_valid_q <= lsb_valid_d;
      lsb_val_q   <= lsb_val_d;
      if_valid_q  <= if_valid_d;
      if_data_q   <= if_data_d;
    end
  end

  assign mem_a         = mem_a_q;
  assign mem_dout      = mem_dout_q;
  assign mem_wr        = mem_wr_q;
  assign lsb_mem_valid = lsb_valid_q;
  assign lsb_mem_val   = lsb_val_q;
  assign if_valid      = if_valid_q;
  assign if_data       = if_data_q;

endmodule
